// File: rtl/cdr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cdr_ctrl_pkg
// Shared types, constants and arithmetic helpers for the RX CDR loop controller.
//   PHASE_W      : phase interpolator code width (2-bit quadrant + 7-bit gain)
//   loop_state_e : IDLE / ACQUIRE / TRACK
//   vote_dir_e   : decided window direction (-1 / 0 / +1)
//   saturate()   : clip an integer to the signed range of a given width
//   clamp()      : clip an integer to +/- limit
// -----------------------------------------------------------------------------
package cdr_ctrl_pkg;

  localparam int PHASE_W = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } loop_state_e;

  typedef enum logic signed [1:0] {
    DIR_DN   = 2'sb11,
    DIR_NONE = 2'sb00,
    DIR_UP   = 2'sb01
  } vote_dir_e;

  function automatic int dir_value(input vote_dir_e d);
    case (d)
      DIR_UP:  return 1;
      DIR_DN:  return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int saturate(input int value, input int width);
    int hi;
    int lo;
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  function automatic int clamp(input int value, input int limit);
    if (value > limit) return limit;
    if (value < -limit) return -limit;
    return value;
  endfunction

endpackage

// File: rtl/cdr_vote_accumulator.sv
// -----------------------------------------------------------------------------
// cdr_vote_accumulator
// Collects VOTE_WIN accepted early/late votes into a signed net sum and decides
// the window direction on the cycle the last vote is accepted.
//   clk, reset   : clock, synchronous active-high reset
//   clear        : discard the partial window (loop idle / overridden)
//   vote_valid   : vote present this cycle
//   early, late  : phase detector votes (+1 / -1, both or neither = 0)
//   window_done  : combinational, high on the cycle the window closes
//   dir          : decided direction, valid while window_done is high
// -----------------------------------------------------------------------------
module cdr_vote_accumulator
  import cdr_ctrl_pkg::*;
#(
  parameter int VOTE_WIN    = 8,
  parameter int VOTE_THRESH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      clear,
  input  logic      vote_valid,
  input  logic      early,
  input  logic      late,
  output logic      window_done,
  output vote_dir_e dir
);

  localparam int CNT_W = $clog2(VOTE_WIN + 1);
  localparam int NET_W = $clog2(VOTE_WIN) + 2;
  localparam logic signed [NET_W-1:0] THRESH = NET_W'(VOTE_THRESH);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [NET_W-1:0] net_q, net_d;
  logic signed [NET_W-1:0] vote_val;
  logic signed [NET_W-1:0] net_sum;
  logic                    last_vote;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    vote_val = '0;
    if (early && !late) vote_val = NET_W'(1);
    if (late && !early) vote_val = NET_W'(-1);

    // The closing vote itself is part of the decision.
    net_sum     = net_q + vote_val;
    last_vote   = (cnt_q == CNT_W'(VOTE_WIN - 1));
    window_done = vote_valid && !clear && last_vote;

    dir = DIR_NONE;
    if (window_done) begin
      if (net_sum >= THRESH)       dir = DIR_UP;
      else if (net_sum <= -THRESH) dir = DIR_DN;
    end

    cnt_d = cnt_q;
    net_d = net_q;
    if (clear) begin
      cnt_d = '0;
      net_d = '0;
    end else if (vote_valid) begin
      if (last_vote) begin
        cnt_d = '0;
        net_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        net_d = net_sum;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their _d values from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      net_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      net_q <= net_d;
    end
  end

endmodule

// File: rtl/cdr_phase_controller.sv
// -----------------------------------------------------------------------------
// cdr_phase_controller
// Second-order bang-bang CDR loop: windowed majority votes drive a proportional
// step plus an integral frequency accumulator; the resulting 9-bit phase code
// wraps modulo 2^PHASE_W. An IDLE/ACQUIRE/TRACK machine provides lock detect.
//   clk, reset    : clock, synchronous active-high reset
//   enable        : loop enable (low forces IDLE, holds phase/freq)
//   vote_valid    : vote present; early raises, late lowers the phase code
//   phase_shift   : code to the phase interpolator
//   phase_update  : one-cycle pulse whenever phase_shift is re-registered
//   freq_word     : signed integral accumulator
//   locked        : high in TRACK
//   loop_state    : current FSM state
// Optional build macro CDR_PHASE_OVERRIDE_EN adds ovr_en / ovr_code: while
// ovr_en is high the phase code is forced, votes are dropped, freq is held.
// -----------------------------------------------------------------------------
module cdr_phase_controller
  import cdr_ctrl_pkg::*;
#(
  parameter int VOTE_WIN       = 8,
  parameter int VOTE_THRESH    = 2,
  parameter int KP_ACQ         = 4,
  parameter int KP_TRK         = 1,
  parameter int FREQ_W         = 10,
  parameter int KI_SHIFT       = 4,
  parameter int MAX_STEP       = 8,
  parameter int LOCK_WINDOWS   = 16,
  parameter int UNLOCK_WINDOWS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               vote_valid,
  input  logic               early,
  input  logic               late,
`ifdef CDR_PHASE_OVERRIDE_EN
  input  logic               ovr_en,
  input  logic [PHASE_W-1:0] ovr_code,
`endif
  output logic [PHASE_W-1:0] phase_shift,
  output logic               phase_update,
  output logic [FREQ_W-1:0]  freq_word,
  output logic               locked,
  output logic [1:0]         loop_state
);

  localparam int DITH_W = $clog2(LOCK_WINDOWS + 1);
  localparam int RUN_W  = $clog2(UNLOCK_WINDOWS + 1);

  loop_state_e              state_q, state_d;
  logic [PHASE_W-1:0]       phase_q, phase_d;
  logic                     update_q, update_d;
  logic signed [FREQ_W-1:0] freq_q, freq_d;
  vote_dir_e                last_dir_q, last_dir_d;
  logic [DITH_W-1:0]        dither_q, dither_d, dither_next;
  logic [RUN_W-1:0]         run_q, run_d, run_next;

  logic      acc_clear;
  logic      window_done;
  vote_dir_e win_dir;
  logic      same_dir;
  int        kp_i, dir_i, freq_new_i, step_i;

`ifdef CDR_PHASE_OVERRIDE_EN
  assign acc_clear = !enable || ovr_en;
`else
  assign acc_clear = !enable;
`endif

  cdr_vote_accumulator #(
    .VOTE_WIN    (VOTE_WIN),
    .VOTE_THRESH (VOTE_THRESH)
  ) u_vote_acc (
    .clk         (clk),
    .reset       (reset),
    .clear       (acc_clear),
    .vote_valid  (vote_valid),
    .early       (early),
    .late        (late),
    .window_done (window_done),
    .dir         (win_dir)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    update_d   = 1'b0;
    freq_d     = freq_q;
    last_dir_d = last_dir_q;
    dither_d   = dither_q;
    run_d      = run_q;

    // Loop arithmetic in int, then narrowed; the narrowing cast of the step
    // is exactly the modulo-2^PHASE_W wrap of the phase code.
    kp_i       = (state_q == TRACK) ? KP_TRK : KP_ACQ;
    dir_i      = dir_value(win_dir);
    freq_new_i = saturate(int'(freq_q) + dir_i, FREQ_W);
    step_i     = clamp(kp_i * dir_i + (freq_new_i >>> KI_SHIFT), MAX_STEP);

    // A window with no previous nonzero direction counts as dithering.
    same_dir    = (win_dir != DIR_NONE) && (win_dir == last_dir_q);
    dither_next = same_dir ? '0 : dither_q + DITH_W'(1);
    if (same_dir)
      run_next = (run_q >= RUN_W'(UNLOCK_WINDOWS)) ? run_q : run_q + RUN_W'(1);
    else
      run_next = (win_dir != DIR_NONE) ? RUN_W'(1) : '0;

`ifdef CDR_PHASE_OVERRIDE_EN
    if (ovr_en) begin
      phase_d    = ovr_code;
      update_d   = (ovr_code != phase_q);
      state_d    = enable ? ACQUIRE : IDLE;
      last_dir_d = DIR_NONE;
      dither_d   = '0;
      run_d      = '0;
    end else
`endif
    if (!enable) begin
      state_d    = IDLE;
      last_dir_d = DIR_NONE;
      dither_d   = '0;
      run_d      = '0;
    end else begin
      if (state_q == IDLE) state_d = ACQUIRE;
      if (window_done) begin
        freq_d   = FREQ_W'(freq_new_i);
        phase_d  = phase_q + PHASE_W'(step_i);
        update_d = 1'b1;
        run_d    = run_next;
        if (win_dir != DIR_NONE) last_dir_d = win_dir;
        if (state_q == TRACK) begin
          if (run_next >= RUN_W'(UNLOCK_WINDOWS)) begin
            state_d  = ACQUIRE;
            dither_d = '0;
          end
        end else if (dither_next >= DITH_W'(LOCK_WINDOWS)) begin
          state_d  = TRACK;
          dither_d = '0;
        end else begin
          state_d  = ACQUIRE;
          dither_d = dither_next;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      update_q   <= 1'b0;
      freq_q     <= '0;
      last_dir_q <= DIR_NONE;
      dither_q   <= '0;
      run_q      <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      update_q   <= update_d;
      freq_q     <= freq_d;
      last_dir_q <= last_dir_d;
      dither_q   <= dither_d;
      run_q      <= run_d;
    end
  end

  assign phase_shift  = phase_q;
  assign phase_update = update_q;
  assign freq_word    = freq_q;
  assign locked       = (state_q == TRACK);
  assign loop_state   = state_q;

endmodule

// File: tb/tb_cdr_phase_controller.sv
// -----------------------------------------------------------------------------
// tb_cdr_phase_controller
// Directed stimulus; each closed window pushes its expected phase/freq/state
// into a scoreboard queue that a negedge monitor pops on every phase_update.
// Spec examples are additionally checked against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_cdr_phase_controller;
  import cdr_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               reset, enable, vote_valid, early, late;
  logic [PHASE_W-1:0] phase_shift;
  logic               phase_update;
  logic [9:0]         freq_word;
  logic               locked;
  logic [1:0]         loop_state;
`ifdef CDR_PHASE_OVERRIDE_EN
  logic               ovr_en;
  logic [PHASE_W-1:0] ovr_code;
`endif

  always #5 clk = ~clk;

  cdr_phase_controller dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .vote_valid   (vote_valid),
    .early        (early),
    .late         (late),
`ifdef CDR_PHASE_OVERRIDE_EN
    .ovr_en       (ovr_en),
    .ovr_code     (ovr_code),
`endif
    .phase_shift  (phase_shift),
    .phase_update (phase_update),
    .freq_word    (freq_word),
    .locked       (locked),
    .loop_state   (loop_state)
  );

  typedef struct {
    int phase;
    int freq;
    int state;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_updates = 0;
  int   u0, prev_phase;

  // Reference loop state
  int m_phase, m_freq, m_state, m_last, m_dither, m_run;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every phase_update must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (phase_update) begin
      n_updates++;
      if (sb.size() == 0) begin
        check("unexpected_update", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb_phase", int'(phase_shift), e.phase);
        check("sb_freq", int'($signed(freq_word)), e.freq);
        check("sb_state", int'(loop_state), e.state);
        check("sb_locked", int'(locked), (e.state == 2) ? 1 : 0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_clear_ctl();
    m_last   = 0;
    m_dither = 0;
    m_run    = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    sb.delete();
    m_phase = 0;
    m_freq  = 0;
    m_state = 0;
    model_clear_ctl();
  endtask

  task automatic start_loop();
    enable = 1'b1;
    tick();
    m_state = 1;
  endtask

  task automatic vote(input logic e, input logic l);
    vote_valid = 1'b1;
    early      = e;
    late       = l;
    tick();
    vote_valid = 1'b0;
    early      = 1'b0;
    late       = 1'b0;
  endtask

  // Expected result of one window with ne early and nl late votes.
  task automatic model_window(input int ne, input int nl);
    int net, dir, kp, f, s;
    bit same;
    net = ne - nl;
    dir = (net >= 2) ? 1 : ((net <= -2) ? -1 : 0);
    kp  = (m_state == 2) ? 1 : 4;
    f   = m_freq + dir;
    if (f > 511)  f = 511;
    if (f < -512) f = -512;
    s = kp * dir + (f >>> 4);
    if (s > 8)  s = 8;
    if (s < -8) s = -8;
    m_freq  = f;
    m_phase = (m_phase + s + 512) % 512;
    same = (dir != 0) && (dir == m_last);
    if (dir != 0) m_last = dir;
    m_run = same ? ((m_run >= 4) ? 4 : m_run + 1) : ((dir != 0) ? 1 : 0);
    if (m_state == 2) begin
      if (m_run >= 4) begin
        m_state  = 1;
        m_dither = 0;
      end
    end else begin
      m_dither = same ? 0 : m_dither + 1;
      m_state  = 1;
      if (m_dither >= 16) begin
        m_state  = 2;
        m_dither = 0;
      end
    end
    sb.push_back('{phase: m_phase, freq: m_freq, state: m_state});
  endtask

  task automatic send_window(input int ne, input int nl);
    model_window(ne, nl);
    for (int i = 0; i < 8; i++)
      vote(i < ne, (i >= ne) && (i < ne + nl));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; vote_valid = 1'b0; early = 1'b0; late = 1'b0;
`ifdef CDR_PHASE_OVERRIDE_EN
    ovr_en = 1'b0; ovr_code = '0;
`endif
    do_reset();
    tick();
    check("rst_phase", int'(phase_shift), 0);
    check("rst_update", int'(phase_update), 0);
    check("rst_freq", int'($signed(freq_word)), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_state", int'(loop_state), 0);

    // 8 early votes: +4 step, freq 1
    start_loop();
    send_window(8, 0);
    check("early_update", int'(phase_update), 1);
    check("early_phase", int'(phase_shift), 4);
    check("early_freq", int'($signed(freq_word)), 1);
    check("early_state", int'(loop_state), 1);

    // 8 late votes: -4 + (-1 >>> 4) = -5 -> wraps to 507
    do_reset();
    start_loop();
    send_window(0, 8);
    check("late_phase", int'(phase_shift), 507);
    check("late_freq", int'($signed(freq_word)), -1);

    // 5/3 then 4/4 (below threshold: no move, still a pulse)
    do_reset();
    start_loop();
    send_window(5, 3);
    check("maj_phase", int'(phase_shift), 4);
    send_window(4, 4);
    check("tie_update", int'(phase_update), 1);
    check("tie_phase", int'(phase_shift), 4);

    // Alternating windows lock after the 16th; 4 same-dir windows unlock
    do_reset();
    start_loop();
    for (int w = 0; w < 16; w++) begin
      send_window((w % 2 == 0) ? 8 : 0, (w % 2 == 1) ? 8 : 0);
      if (w == 14) check("lock_before_16", int'(locked), 0);
    end
    check("lock_locked", int'(locked), 1);
    check("lock_state", int'(loop_state), 2);
    for (int w = 0; w < 4; w++) begin
      send_window(8, 0);
      if (w == 2) check("unlock_before_4", int'(locked), 1);
    end
    check("unlock_locked", int'(locked), 0);
    check("unlock_state", int'(loop_state), 1);

    // Enable drop discards a partial window
    do_reset();
    start_loop();
    for (int i = 0; i < 5; i++) vote(1'b1, 1'b0);
    enable = 1'b0;
    m_state = 0;
    model_clear_ctl();
    tick(3);
    check("dis_state", int'(loop_state), 0);
    start_loop();
    u0 = n_updates;
    send_window(8, 0);
    tick(2);
    check("dis_one_update", n_updates - u0, 1);
    check("dis_phase", int'(phase_shift), 4);

    // Reset mid-window discards partial votes
    do_reset();
    start_loop();
    for (int i = 0; i < 5; i++) vote(1'b1, 1'b0);
    do_reset();
    start_loop();
    send_window(8, 0);
    check("rstmid_phase", int'(phase_shift), 4);

    // 600 early windows: freq saturates at 511, step clamps to +8
    do_reset();
    start_loop();
    prev_phase = 0;
    for (int w = 0; w < 600; w++) begin
      prev_phase = int'(phase_shift);
      send_window(8, 0);
    end
    check("sat_freq", int'($signed(freq_word)), 511);
    check("clamp_step", (int'(phase_shift) - prev_phase + 512) % 512, 8);

`ifdef CDR_PHASE_OVERRIDE_EN
    ovr_en   = 1'b1;
    ovr_code = 9'd300;
    if (m_phase != 300) sb.push_back('{phase: 300, freq: 511, state: 1});
    tick();
    check("ovr_phase", int'(phase_shift), 300);
    check("ovr_freq", int'($signed(freq_word)), 511);
    u0 = n_updates;
    for (int i = 0; i < 8; i++) vote(1'b1, 1'b0);
    tick();
    check("ovr_votes_ignored", n_updates - u0, 0);
    check("ovr_hold_phase", int'(phase_shift), 300);
    ovr_en  = 1'b0;
    m_phase = 300;
    m_state = 1;
    model_clear_ctl();
    tick();
    send_window(8, 0);
    check("ovr_resume_phase", int'(phase_shift), 308);
`endif

    tick(3);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
